// File: rtl/ssm_pkg.sv
// ---------------------------------------------------------------------------
// ssm_pkg
// Shared types and constants for the shadow stack monitor.
//   ssm_state_e   : monitor state (DISABLED / RUN / ALARM)
//   ssm_entry_t   : one return-address entry (default VLEN = 32)
//   priv_lvl_e    : RISC-V privilege encoding used for the user-mode gate
//   INSTR_LEN_C   : byte length of a full-size instruction
//   INSTR_LEN_RVC : byte length of a compressed instruction
// ---------------------------------------------------------------------------
package ssm_pkg;

  localparam int unsigned VLEN_DEFAULT  = 32;
  localparam int unsigned INSTR_LEN_C   = 4;
  localparam int unsigned INSTR_LEN_RVC = 2;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    ALARM    = 2'd2
  } ssm_state_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  typedef logic [VLEN_DEFAULT-1:0] ssm_entry_t;

endpackage

// File: rtl/ssm_lifo.sv
// ---------------------------------------------------------------------------
// ssm_lifo
// Circular LIFO holding return addresses. When full, a push overwrites the
// oldest entry and reports the loss on drop_o. A simultaneous push and pop
// replaces the top entry in place. A pop on an empty LIFO is ignored.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous empty (overrides push/pop)
//   push_i, pop_i : operation requests
//   data_i        : address to push
//   top_o         : current top-of-stack (undefined when count_o == 0)
//   count_o       : number of valid entries (registered)
//   drop_o        : this cycle's push discards the oldest entry
// ---------------------------------------------------------------------------
module ssm_lifo #(
  parameter int VLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [VLEN-1:0]  data_i,
  output logic [VLEN-1:0]  top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             drop_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [VLEN-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_replace;
  logic [PTR_W-1:0] w_wr_ptr;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop     = pop_i & ~w_empty;
  assign w_replace = push_i & w_pop;
  // Writing one slot above the top; when full that slot is the oldest entry.
  assign w_wr_ptr  = w_replace ? r_top : r_top + PTR_W'(1);

  assign top_o   = r_mem[r_top];
  assign count_o = r_count;
  assign drop_o  = push_i & ~w_pop & w_full & ~clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (w_replace) begin
      r_top   <= r_top;
    end else if (push_i) begin
      r_top <= r_top + PTR_W'(1);
      if (!w_full) r_count <= r_count + CNT_W'(1);
    end else if (w_pop) begin
      r_top   <= r_top - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) r_mem[w_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/shadow_stack_monitor.sv
// ---------------------------------------------------------------------------
// shadow_stack_monitor
// Keeps a hardware shadow copy of return addresses for resolved calls and
// checks every resolved return target against it. A mismatch raises a sticky
// violation and a one-cycle crash request for the branch unit.
// Checking is active only in user privilege while the monitor is enabled.
// Optional feature macro: SHADOW_STACK_PERF_CNT_EN (adds saturating event
// counters calls_cnt_o, returns_cnt_o, underflow_cnt_o).
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   en_i              : monitoring enable
//   flush_i           : drop this cycle's event (stack kept)
//   clear_i           : empty stack, clear violation/overflow, leave ALARM
//   priv_lvl_i        : current privilege level
//   valid_i           : resolved branch event valid
//   is_call_i         : event is a call
//   is_return_i       : event is a return
//   pc_i              : PC of the resolved instruction
//   is_compressed_i   : instruction is 16-bit
//   target_i          : resolved jump target
//   violation_o       : sticky mismatch flag
//   crash_req_o       : one-cycle crash request
//   depth_o           : valid shadow entries
//   overflow_o        : sticky, an entry has been discarded
// ---------------------------------------------------------------------------
module shadow_stack_monitor
  import ssm_pkg::*;
#(
  parameter int VLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             clear_i,
  input  logic [1:0]       priv_lvl_i,
  input  logic             valid_i,
  input  logic             is_call_i,
  input  logic             is_return_i,
  input  logic [VLEN-1:0]  pc_i,
  input  logic             is_compressed_i,
  input  logic [VLEN-1:0]  target_i,
  output logic             violation_o,
  output logic             crash_req_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             overflow_o
`ifdef SHADOW_STACK_PERF_CNT_EN
  ,
  output logic [31:0]      calls_cnt_o,
  output logic [31:0]      returns_cnt_o,
  output logic [31:0]      underflow_cnt_o
`endif
);

  ssm_state_e       r_state;
  logic             r_violation;
  logic             r_crash;
  logic             r_overflow;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_mismatch;
  logic             w_drop;
  logic [VLEN-1:0]  w_ret_addr;
  logic [VLEN-1:0]  w_top;
  logic [CNT_W-1:0] w_count;

  // Clear has priority over any event arriving in the same cycle.
  assign w_accept = valid_i & ~flush_i & ~clear_i &
                    (priv_lvl_i == PRIV_LVL_U) & (r_state == RUN);

  assign w_ret_addr = pc_i + (is_compressed_i ? VLEN'(INSTR_LEN_RVC)
                                              : VLEN'(INSTR_LEN_C));

  // Returns at depth 0 are tolerated: entries may have been lost to overflow.
  assign w_pop      = w_accept & is_return_i & (w_count != '0);
  assign w_mismatch = w_pop & (target_i != w_top);
  assign w_push     = w_accept & is_call_i;

  ssm_lifo #(
    .VLEN  (VLEN),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_lifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_ret_addr),
    .top_o   (w_top),
    .count_o (w_count),
    .drop_o  (w_drop)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= DISABLED;
      r_violation <= 1'b0;
      r_crash     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_crash <= 1'b0;
      if (clear_i) begin
        r_violation <= 1'b0;
        r_overflow  <= 1'b0;
        r_state     <= en_i ? RUN : DISABLED;
      end else begin
        if (w_drop) r_overflow <= 1'b1;
        if (w_mismatch) begin
          r_violation <= 1'b1;
          r_crash     <= 1'b1;
        end
        unique case (r_state)
          DISABLED: if (en_i) r_state <= RUN;
          RUN: begin
            if (w_mismatch) r_state <= ALARM;
            else if (!en_i) r_state <= DISABLED;
          end
          ALARM:    if (!en_i) r_state <= DISABLED;
          default:  r_state <= DISABLED;
        endcase
      end
    end
  end

  assign violation_o = r_violation;
  assign crash_req_o = r_crash;
  assign overflow_o  = r_overflow;
  assign depth_o     = w_count;

`ifdef SHADOW_STACK_PERF_CNT_EN
  logic [31:0] r_calls_cnt;
  logic [31:0] r_returns_cnt;
  logic [31:0] r_underflow_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_calls_cnt     <= '0;
      r_returns_cnt   <= '0;
      r_underflow_cnt <= '0;
    end else if (clear_i) begin
      r_calls_cnt     <= '0;
      r_returns_cnt   <= '0;
      r_underflow_cnt <= '0;
    end else begin
      if (w_accept && is_call_i && (r_calls_cnt != '1))
        r_calls_cnt <= r_calls_cnt + 32'd1;
      if (w_accept && is_return_i && (r_returns_cnt != '1))
        r_returns_cnt <= r_returns_cnt + 32'd1;
      if (w_accept && is_return_i && (w_count == '0) && (r_underflow_cnt != '1))
        r_underflow_cnt <= r_underflow_cnt + 32'd1;
    end
  end

  assign calls_cnt_o     = r_calls_cnt;
  assign returns_cnt_o   = r_returns_cnt;
  assign underflow_cnt_o = r_underflow_cnt;
`endif

endmodule

// File: tb/tb_shadow_stack_monitor.sv
module tb_shadow_stack_monitor;

  localparam int VLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  localparam int M_DIS = 0;
  localparam int M_RUN = 1;
  localparam int M_ALM = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             en_i, flush_i, clear_i, valid_i, is_call_i, is_return_i;
  logic             is_compressed_i;
  logic [1:0]       priv_lvl_i;
  logic [VLEN-1:0]  pc_i, target_i;
  logic             violation_o, crash_req_o, overflow_o;
  logic [CNT_W-1:0] depth_o;
`ifdef SHADOW_STACK_PERF_CNT_EN
  logic [31:0]      calls_cnt_o, returns_cnt_o, underflow_cnt_o;
`endif

  shadow_stack_monitor #(.VLEN(VLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .en_i            (en_i),
    .flush_i         (flush_i),
    .clear_i         (clear_i),
    .priv_lvl_i      (priv_lvl_i),
    .valid_i         (valid_i),
    .is_call_i       (is_call_i),
    .is_return_i     (is_return_i),
    .pc_i            (pc_i),
    .is_compressed_i (is_compressed_i),
    .target_i        (target_i),
    .violation_o     (violation_o),
    .crash_req_o     (crash_req_o),
    .depth_o         (depth_o),
    .overflow_o      (overflow_o)
`ifdef SHADOW_STACK_PERF_CNT_EN
    ,
    .calls_cnt_o     (calls_cnt_o),
    .returns_cnt_o   (returns_cnt_o),
    .underflow_cnt_o (underflow_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of return addresses (back = top).
  logic [31:0] mq[$];
  int          mstate;
  bit          mviol, mcrash, movf;

  task automatic model_reset();
    mq.delete();
    mstate = M_DIS;
    mviol  = 0;
    mcrash = 0;
    movf   = 0;
  endtask

  // Apply one clock edge's worth of the rules to the model, using the inputs
  // that were presented to the DUT for that edge.
  task automatic model_clock();
    bit acc, mism;
    logic [31:0] ra;
    mcrash = 0;
    if (clear_i) begin
      mq.delete();
      mviol  = 0;
      movf   = 0;
      mstate = en_i ? M_RUN : M_DIS;
    end else begin
      acc  = valid_i && !flush_i && (priv_lvl_i == 2'b00) && (mstate == M_RUN);
      mism = 0;
      if (acc && is_return_i && mq.size() > 0) begin
        if (target_i != mq[$]) mism = 1;
        void'(mq.pop_back());
      end
      if (acc && is_call_i) begin
        ra = pc_i + (is_compressed_i ? 32'd2 : 32'd4);
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          movf = 1;
        end
        mq.push_back(ra);
      end
      if (mism) begin
        mviol  = 1;
        mcrash = 1;
      end
      case (mstate)
        M_DIS: if (en_i) mstate = M_RUN;
        M_RUN: if (mism) mstate = M_ALM; else if (!en_i) mstate = M_DIS;
        default: if (!en_i) mstate = M_DIS;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".depth"}, 64'(depth_o), 64'(mq.size()));
    chk({tag, ".viol"},  64'(violation_o), 64'(mviol));
    chk({tag, ".crash"}, 64'(crash_req_o), 64'(mcrash));
    chk({tag, ".ovf"},   64'(overflow_o), 64'(movf));
  endtask

  task automatic step(input bit en, input bit clr, input bit fl, input bit v,
                      input bit c, input bit r, input bit rvc, input logic [1:0] pv,
                      input logic [31:0] pc, input logic [31:0] tg, input string tag);
    en_i = en; clear_i = clr; flush_i = fl; valid_i = v;
    is_call_i = c; is_return_i = r; is_compressed_i = rvc;
    priv_lvl_i = pv; pc_i = pc; target_i = tg;
    @(posedge clk_i);
    model_clock();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, tag);
  endtask

  task automatic call(input logic [31:0] pc, input bit rvc, input string tag);
    step(1, 0, 0, 1, 1, 0, rvc, 2'b00, pc, 32'h0, tag);
  endtask

  task automatic ret(input logic [31:0] tg, input string tag);
    step(1, 0, 0, 1, 0, 1, 0, 2'b00, 32'h0, tg, tag);
  endtask

  task automatic do_clear(input string tag);
    step(1, 1, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, tag);
  endtask

  initial begin
    rst_ni = 1'b0;
    en_i = 0; flush_i = 0; clear_i = 0; valid_i = 0; is_call_i = 0;
    is_return_i = 0; is_compressed_i = 0; priv_lvl_i = 2'b00;
    pc_i = '0; target_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    rst_ni = 1'b1;

    idle("enable");

    // Matching call/return
    call(32'h8000_0100, 0, "t1.call");
    ret(32'h8000_0104, "t1.ret");

    // Mismatch on compressed call
    call(32'h8000_0200, 1, "t2.call");
    ret(32'h8000_0000, "t2.badret");
    idle("t2.after");
    call(32'h8000_0300, 0, "t2.ignored_call");
    ret(32'h1234_5678, "t2.ignored_ret");
    do_clear("t2.clear");

    // Overflow and underflow
    for (int i = 0; i <= DEPTH; i++) call(32'h1000 + 32'(8 * i), 0, "t3.call");
    for (int i = DEPTH; i >= 1; i--) ret(32'h1000 + 32'(8 * i) + 32'd4, "t3.ret");
    ret(32'hDEAD_BEE0, "t3.underflow");
    do_clear("t3.clear");

    // Gated events
    step(1, 0, 0, 1, 1, 0, 0, 2'b11, 32'h500, 32'h0, "t4.priv_m");
    step(1, 0, 1, 1, 1, 0, 0, 2'b00, 32'h500, 32'h0, "t4.flush");
    step(0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, "t4.disable");
    step(0, 0, 0, 1, 1, 0, 0, 2'b00, 32'h500, 32'h0, "t4.en0");
    idle("t4.reenable");

    // Coroutine swap
    call(32'h300, 0, "t5.call");
    step(1, 0, 0, 1, 1, 1, 0, 2'b00, 32'h400, 32'h304, "t5.swap");
    ret(32'h404, "t5.ret");

    // Back-to-back with async reset mid-sequence
    for (int i = 0; i < 4; i++) call(32'h2000 + 32'(16 * i), i[0], "t6.call");
    for (int i = 3; i >= 0; i--) ret(32'h2000 + 32'(16 * i) + (i[0] ? 32'd2 : 32'd4), "t6.ret");
    for (int i = 0; i < 3; i++) call(32'h3000 + 32'(4 * i), 0, "t6.precall");
    rst_ni = 1'b0;
    #2;
    model_reset();
    check_all("t6.reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle("t6.enable");
    ret(32'h3008, "t6.empty_ret");

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      bit en, clr, fl, v, c, r, rvc;
      logic [1:0] pv;
      logic [31:0] pc, tg;
      int k;
      en  = ($urandom_range(99) >= 3);
      clr = (mstate == M_ALM) ? ($urandom_range(99) < 10) : ($urandom_range(199) == 0);
      fl  = ($urandom_range(99) < 5);
      v   = ($urandom_range(99) < 75);
      pv  = ($urandom_range(99) < 90) ? 2'b00 : ($urandom_range(1) ? 2'b11 : 2'b01);
      k   = $urandom_range(99);
      c   = (k < 50) || (k >= 90);
      r   = (k >= 50);
      rvc = $urandom_range(1);
      pc  = $urandom & 32'hFFFF_FFFE;
      if (mq.size() > 0 && $urandom_range(99) < 95) tg = mq[$];
      else tg = $urandom;
      step(en, clr, fl, v, c, r, rvc, pv, pc, tg, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
